battery_level_monitor: RTL and testbench

Parametrised battery-level monitor for N battery channels. It sums the per-battery gauge readings on each sample strobe and classifies the total into five levels: critical, low, medium, high and full. A level change is accepted only after it has been seen on several consecutive samples, and downward moves are subject to hysteresis. It drives active-low one-hot level indicators plus a blinking critical alarm, and sits between the battery gauge readers and the front-panel LED/alarm driver.

---
 rtl/battery_level_monitor.sv | 171 +++++++++++++++++
 tb/tb_battery_level_monitor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/battery_level_monitor.sv
// Battery-level monitor: sums N_BAT gauge readings per strobe, classifies the total into
// five levels with consecutive-sample qualification, downward hysteresis and a blinking alarm.
module battery_level_monitor #(
  parameter int N_BAT      = 2,
  parameter int BAT_W      = 4,
  parameter int SUM_W      = BAT_W + $clog2(N_BAT),
  parameter int T_LOW      = 3,
  parameter int T_MED      = 10,
  parameter int T_HIGH     = 19,
  parameter int HYST       = 1,
  parameter int STABLE_CNT = 2,
  parameter int BLINK_DIV  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_en,
  input  logic [N_BAT*BAT_W-1:0] bat_bus,
  output logic [SUM_W-1:0]       sum_q,
  output logic [4:0]             lvl_n,
  output logic                   level_valid,
  output logic                   changed,
  output logic                   alarm_n
);

  // level | meaning
  // CRIT  | sum < T_LOW, alarm blinks
  // LOW   | T_LOW  <= sum < T_MED
  // MED   | T_MED  <= sum < T_HIGH
  // HIGH  | T_HIGH <= sum < FULL_V
  // FULL  | sum == FULL_V
  typedef enum logic [2:0] {
    LVL_CRIT = 3'd0,
    LVL_LOW  = 3'd1,
    LVL_MED  = 3'd2,
    LVL_HIGH = 3'd3,
    LVL_FULL = 3'd4
  } level_t;

  localparam int FULL_V = N_BAT * ((1 << BAT_W) - 1);
  localparam int CNT_W  = $clog2(STABLE_CNT + 1);
  localparam int DIV_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SUM_W-1:0] r_sum_q;
  logic             r_sum_vld;
  level_t           r_level;
  level_t           r_pend;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_lvl_n;
  logic             r_level_valid;
  logic             r_changed;
  logic             r_alarm_n;
  logic [DIV_W-1:0] r_div;

  logic [SUM_W-1:0] w_sum;
  logic [31:0]      w_sum_ext;
  logic [31:0]      w_hyst_floor;
  level_t           w_raw;
  level_t           w_cand;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_load;

  function automatic int lower_bound(input level_t lvl);
    case (lvl)
      LVL_LOW:  return T_LOW;
      LVL_MED:  return T_MED;
      LVL_HIGH: return T_HIGH;
      LVL_FULL: return FULL_V;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [4:0] onehot_n(input level_t lvl);
    case (lvl)
      LVL_CRIT: return 5'b01111;
      LVL_LOW:  return 5'b10111;
      LVL_MED:  return 5'b11011;
      LVL_HIGH: return 5'b11101;
      LVL_FULL: return 5'b11110;
      default:  return 5'b11111;
    endcase
  endfunction

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_BAT; i++) begin
      w_sum = w_sum + SUM_W'(bat_bus[i*BAT_W +: BAT_W]);
    end
  end

  assign w_sum_ext    = 32'(r_sum_q);
  // HYST < T_LOW keeps this non-negative for every level that can be left downward.
  assign w_hyst_floor = $unsigned(lower_bound(r_level) - HYST);

  always_comb begin
    w_raw = LVL_CRIT;
    if (w_sum_ext == $unsigned(FULL_V))      w_raw = LVL_FULL;
    else if (w_sum_ext >= $unsigned(T_HIGH)) w_raw = LVL_HIGH;
    else if (w_sum_ext >= $unsigned(T_MED))  w_raw = LVL_MED;
    else if (w_sum_ext >= $unsigned(T_LOW))  w_raw = LVL_LOW;
  end

  always_comb begin
    w_cand = w_raw;
    if (r_level_valid && (w_raw < r_level) && (w_sum_ext >= w_hyst_floor)) begin
      w_cand = r_level;
    end
  end

  always_comb begin
    w_cnt_nxt = CNT_W'(1);
    if (w_cand == r_pend) begin
      w_cnt_nxt = (r_cnt == CNT_W'(STABLE_CNT)) ? r_cnt : r_cnt + CNT_W'(1);
    end
  end

  assign w_load = r_sum_vld && (w_cnt_nxt == CNT_W'(STABLE_CNT)) &&
                  (!r_level_valid || (w_cand != r_level));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum_q       <= '0;
      r_sum_vld     <= 1'b0;
      r_level       <= LVL_CRIT;
      r_pend        <= LVL_CRIT;
      r_cnt         <= '0;
      r_lvl_n       <= 5'b11111;
      r_level_valid <= 1'b0;
      r_changed     <= 1'b0;
      r_alarm_n     <= 1'b1;
      r_div         <= '0;
    end else begin
      r_sum_vld <= sample_en;
      if (sample_en) r_sum_q <= w_sum;

      r_changed <= 1'b0;
      if (r_sum_vld) begin
        r_pend <= w_cand;
        r_cnt  <= w_cnt_nxt;
        if (w_load) begin
          r_level       <= w_cand;
          r_lvl_n       <= onehot_n(w_cand);
          r_level_valid <= 1'b1;
          r_changed     <= 1'b1;
        end
      end

      // Entering critical starts the blink phase fresh with the alarm asserted.
      if (w_load) begin
        r_alarm_n <= (w_cand != LVL_CRIT);
        r_div     <= '0;
      end else if (r_level_valid && (r_level == LVL_CRIT)) begin
        if (r_div == DIV_W'(BLINK_DIV - 1)) begin
          r_div     <= '0;
          r_alarm_n <= ~r_alarm_n;
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end else begin
        r_alarm_n <= 1'b1;
        r_div     <= '0;
      end
    end
  end

  assign sum_q       = r_sum_q;
  assign lvl_n       = r_lvl_n;
  assign level_valid = r_level_valid;
  assign changed     = r_changed;
  assign alarm_n     = r_alarm_n;

endmodule

// File: tb/tb_battery_level_monitor.sv
// Directed bench for battery_level_monitor: default build plus a 4-channel, 3-bit build.
module tb_battery_level_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_en;
  logic [7:0]  bat_bus;
  logic [4:0]  sum_q;
  logic [4:0]  lvl_n;
  logic        level_valid, changed, alarm_n;

  logic        sample_en2;
  logic [11:0] bat_bus2;
  logic [4:0]  sum_q2;
  logic [4:0]  lvl_n2;
  logic        level_valid2, changed2, alarm_n2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  battery_level_monitor dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .bat_bus(bat_bus),
    .sum_q(sum_q), .lvl_n(lvl_n), .level_valid(level_valid),
    .changed(changed), .alarm_n(alarm_n)
  );

  battery_level_monitor #(.N_BAT(4), .BAT_W(3)) dut4 (
    .clk(clk), .rst(rst), .sample_en(sample_en2), .bat_bus(bat_bus2),
    .sum_q(sum_q2), .lvl_n(lvl_n2), .level_valid(level_valid2),
    .changed(changed2), .alarm_n(alarm_n2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two back-to-back strobes; returns just after the second stage-2 update.
  task automatic pair(input logic [7:0] bus);
    bat_bus = bus; sample_en = 1'b1;
    step(); step();
    sample_en = 1'b0;
    step();
  endtask

  task automatic pair4(input logic [11:0] bus);
    bat_bus2 = bus; sample_en2 = 1'b1;
    step(); step();
    sample_en2 = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b0; bat_bus = '0; sample_en2 = 1'b0; bat_bus2 = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_sum", sum_q, 0);
    chk("rst_lvl", lvl_n, 5'b11111);
    chk("rst_valid", level_valid, 0);
    chk("rst_changed", changed, 0);
    chk("rst_alarm", alarm_n, 1);

    // Full: first qualifying edge must not accept yet
    bat_bus = {4'd15, 4'd15}; sample_en = 1'b1;
    step(); step();
    sample_en = 1'b0;
    chk("full_cnt1_lvl", lvl_n, 5'b11111);
    chk("full_cnt1_valid", level_valid, 0);
    chk("full_sum", sum_q, 30);
    step();
    chk("full_lvl", lvl_n, 5'b11110);
    chk("full_valid", level_valid, 1);
    chk("full_changed", changed, 1);
    step();
    chk("full_changed_pulse", changed, 0);

    pair({4'd14, 4'd15});
    chk("hyst29_lvl", lvl_n, 5'b11110);
    chk("hyst29_changed", changed, 0);
    pair({4'd14, 4'd14});
    chk("high28_lvl", lvl_n, 5'b11101);
    chk("high28_changed", changed, 1);

    pair({4'd6, 4'd6});
    chk("med12_lvl", lvl_n, 5'b11011);

    // Alternating candidates never qualify
    sample_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bat_bus = (k % 2 == 0) ? {4'd10, 4'd10} : {4'd6, 4'd6};
      if (k == 4) sample_en = 1'b0;
      step();
      chk("alt_lvl", lvl_n, 5'b11011);
      chk("alt_changed", changed, 0);
    end
    step();
    chk("alt_final_lvl", lvl_n, 5'b11011);

    pair({4'd2, 4'd3});
    chk("low5_lvl", lvl_n, 5'b10111);
    chk("low5_alarm", alarm_n, 1);

    pair({4'd0, 4'd1});
    chk("crit_lvl", lvl_n, 5'b01111);
    chk("crit_alarm0", alarm_n, 0);
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("blink", alarm_n, (j >= 4 && j < 8) ? 1 : 0);
    end

    pair({4'd4, 4'd5});
    chk("up9_lvl", lvl_n, 5'b10111);
    chk("up9_alarm", alarm_n, 1);

    // sum 2 == T_LOW - HYST: held at low
    pair({4'd1, 4'd1});
    chk("hyst2_lvl", lvl_n, 5'b10111);
    chk("hyst2_changed", changed, 0);

    // Reset while blinking with a pending candidate
    pair({4'd0, 4'd1});
    chk("crit2_lvl", lvl_n, 5'b01111);
    bat_bus = {4'd4, 4'd5}; sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    step();
    step();
    chk("pre_rst_alarm", alarm_n, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_sum", sum_q, 0);
    chk("mid_rst_lvl", lvl_n, 5'b11111);
    chk("mid_rst_valid", level_valid, 0);
    chk("mid_rst_changed", changed, 0);
    chk("mid_rst_alarm", alarm_n, 1);
    step();
    chk("post_rst_alarm", alarm_n, 1);

    bat_bus = {4'd4, 4'd5}; sample_en = 1'b1;
    step(); step();
    sample_en = 1'b0;
    chk("requal_cnt1_valid", level_valid, 0);
    step();
    chk("requal_lvl", lvl_n, 5'b10111);
    chk("requal_valid", level_valid, 1);
    chk("requal_changed", changed, 1);

    // 4 x 3-bit build, FULL_V = 28
    pair4(12'hFFF);
    chk("b4_full_sum", sum_q2, 28);
    chk("b4_full_lvl", lvl_n2, 5'b11110);
    chk("b4_full_valid", level_valid2, 1);
    pair4({3'd6, 3'd7, 3'd7, 3'd7});
    chk("b4_hyst27_lvl", lvl_n2, 5'b11110);
    pair4({3'd5, 3'd7, 3'd7, 3'd7});
    chk("b4_high26_lvl", lvl_n2, 5'b11101);
    chk("b4_high26_changed", changed2, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
